// File: rtl/arc4_encrypt_writer.sv
// ARC4 encryptor: runs init/KSA/PRGA on an external S RAM and writes a length-prefixed CT image.
// Optional: define ARC4_ENC_CYCLE_COUNT_EN to add a 32-bit busy-cycle counter output (cycles).
module arc4_encrypt_writer #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned MSG_AW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [MSG_AW-1:0]      pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [MSG_AW-1:0]      ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren
`ifdef ARC4_ENC_CYCLE_COUNT_EN
    ,
    output logic [31:0]            cycles
`endif
);

    localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [4:0] {
        StIdle,
        StInit,
        StKsaRdI,
        StKsaWaitI,
        StKsaRdJ,
        StKsaWaitJ,
        StKsaWrI,
        StKsaWrJ,
        StLenRd,
        StLenWait,
        StLenWr,
        StPrgaWaitI,
        StPrgaRdJ,
        StPrgaWaitJ,
        StPrgaWrI,
        StPrgaWrJ,
        StPrgaRdPad,
        StPrgaWaitPad,
        StPrgaWrCt,
        StDone
    } state_t;

    state_t                 state;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             k;
    logic [7:0]             len_q;
    logic [7:0]             si_q;
    logic [7:0]             sj_q;
    logic [7:0]             pt_q;
    logic [KIW-1:0]         kidx;
    logic [7:0]             key_byte;
    logic [7:0]             j_ksa;
    logic [7:0]             j_prga;

    // Key byte 0 is the most significant byte of the latched key.
    always_comb begin
        key_byte = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx == KIW'(n)) begin
                key_byte = key_q[8*(KEY_BYTES-n)-1 -: 8];
            end
        end
    end

    assign j_ksa  = j + s_rddata + key_byte;
    assign j_prga = j + s_rddata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            rdy       <= 1'b1;
            key_q     <= '0;
            i         <= 8'h00;
            j         <= 8'h00;
            k         <= 8'h00;
            len_q     <= 8'h00;
            si_q      <= 8'h00;
            sj_q      <= 8'h00;
            pt_q      <= 8'h00;
            kidx      <= '0;
            pt_addr   <= '0;
            ct_addr   <= '0;
            ct_wrdata <= 8'h00;
            ct_wren   <= 1'b0;
            s_addr    <= 8'h00;
            s_wrdata  <= 8'h00;
            s_wren    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (en) begin
                        key_q <= key;
                        rdy   <= 1'b0;
                        i     <= 8'h00;
                        state <= StInit;
                    end
                end
                StInit: begin
                    s_addr   <= i;
                    s_wrdata <= i;
                    s_wren   <= 1'b1;
                    i        <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= 8'h00;
                        kidx  <= '0;
                        state <= StKsaRdI;
                    end
                end
                StKsaRdI: begin
                    s_wren <= 1'b0;
                    s_addr <= i;
                    state  <= StKsaWaitI;
                end
                StKsaWaitI: state <= StKsaRdJ;
                StKsaRdJ: begin
                    si_q   <= s_rddata;
                    j      <= j_ksa;
                    s_addr <= j_ksa;
                    state  <= StKsaWaitJ;
                end
                StKsaWaitJ: state <= StKsaWrI;
                StKsaWrI: begin
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                    state    <= StKsaWrJ;
                end
                StKsaWrJ: begin
                    s_addr   <= j;
                    s_wrdata <= si_q;
                    s_wren   <= 1'b1;
                    i        <= i + 8'd1;
                    kidx     <= (kidx == KIW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
                    state    <= (i == 8'hFF) ? StLenRd : StKsaRdI;
                end
                StLenRd: begin
                    s_wren  <= 1'b0;
                    pt_addr <= '0;
                    state   <= StLenWait;
                end
                StLenWait: state <= StLenWr;
                StLenWr: begin
                    len_q     <= pt_rddata;
                    ct_addr   <= '0;
                    ct_wrdata <= pt_rddata;
                    ct_wren   <= 1'b1;
                    // First PRGA step issued here: i = 0 + 1, PT[1].
                    j         <= 8'h00;
                    i         <= 8'd1;
                    k         <= 8'd1;
                    s_addr    <= 8'd1;
                    pt_addr   <= MSG_AW'(1);
                    state     <= (pt_rddata == 8'h00) ? StDone : StPrgaWaitI;
                end
                StPrgaWaitI: begin
                    ct_wren <= 1'b0;
                    state   <= StPrgaRdJ;
                end
                StPrgaRdJ: begin
                    si_q   <= s_rddata;
                    pt_q   <= pt_rddata;
                    j      <= j_prga;
                    s_addr <= j_prga;
                    state  <= StPrgaWaitJ;
                end
                StPrgaWaitJ: state <= StPrgaWrI;
                StPrgaWrI: begin
                    sj_q     <= s_rddata;
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                    state    <= StPrgaWrJ;
                end
                StPrgaWrJ: begin
                    s_addr   <= j;
                    s_wrdata <= si_q;
                    s_wren   <= 1'b1;
                    state    <= StPrgaRdPad;
                end
                StPrgaRdPad: begin
                    s_wren <= 1'b0;
                    s_addr <= si_q + sj_q;
                    state  <= StPrgaWaitPad;
                end
                StPrgaWaitPad: state <= StPrgaWrCt;
                StPrgaWrCt: begin
                    ct_addr   <= MSG_AW'(k);
                    ct_wrdata <= pt_q ^ s_rddata;
                    ct_wren   <= 1'b1;
                    if (k == len_q) begin
                        state <= StDone;
                    end else begin
                        k       <= k + 8'd1;
                        i       <= i + 8'd1;
                        s_addr  <= i + 8'd1;
                        pt_addr <= MSG_AW'(k + 8'd1);
                        state   <= StPrgaWaitI;
                    end
                end
                StDone: begin
                    ct_wren <= 1'b0;
                    rdy     <= 1'b1;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef ARC4_ENC_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= 32'd0;
        end else if (rdy && en) begin
            cycles <= 32'd0;
        end else if (!rdy) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arc4_encrypt_writer.sv
// Scoreboard bench for arc4_encrypt_writer: expected CT writes are queued per run, a monitor
// pops and compares every ct_wren cycle. Covers ARC4_ENC_CYCLE_COUNT_EN when defined.
module tb_arc4_encrypt_writer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic [7:0]  s_addr;
    logic [7:0]  s_rddata;
    logic [7:0]  s_wrdata;
    logic        s_wren;
`ifdef ARC4_ENC_CYCLE_COUNT_EN
    logic [31:0] cycles;
`endif

    logic [7:0]  pt_mem [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  s_mem  [256];
    logic [7:0]  orig   [256];
    logic [15:0] exp_q  [$];

    logic [7:0]  std_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65,
                                 8'h78, 8'h74};
    logic [7:0]  std_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF,
                                 8'h0A, 8'hD3};

    int total;
    int bad;
    int wr_count;

    arc4_encrypt_writer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren)
`ifdef ARC4_ENC_CYCLE_COUNT_EN
        ,
        .cycles    (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        pt_rddata <= pt_mem[pt_addr];
        if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every CT write must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && ct_wren) begin
            wr_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ct_write_unexpected: got addr=%0d data=%02h expected none",
                         ct_addr, ct_wrdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({ct_addr, ct_wrdata} !== e) begin
                    bad++;
                    $display("FAIL ct_write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                             ct_addr, ct_wrdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    // Reference ARC4 over the current PT image; pushes the full expected CT image.
    task automatic push_model(input logic [23:0] kv);
        int s [256];
        int ii;
        int jj;
        int t;
        int len;
        for (int n = 0; n < 256; n++) s[n] = n;
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            jj = (jj + s[n] + int'((kv >> (8 * (2 - n % 3))) & 24'hFF)) % 256;
            t = s[n]; s[n] = s[jj]; s[jj] = t;
        end
        len = int'(pt_mem[0]);
        exp_q.push_back({8'h00, pt_mem[0]});
        ii = 0;
        jj = 0;
        for (int n = 1; n <= len; n++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            exp_q.push_back({8'(n), pt_mem[n] ^ 8'(s[(s[ii] + s[jj]) % 256])});
        end
    endtask

    task automatic push_std(input bit plain);
        for (int n = 0; n < 10; n++) exp_q.push_back({8'(n), plain ? std_pt[n] : std_ct[n]});
    endtask

    task automatic load_std();
        for (int n = 0; n < 256; n++) pt_mem[n] = (n < 10) ? std_pt[n] : 8'h00;
    endtask

    task automatic load_random(input int len);
        pt_mem[0] = 8'(len);
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    endtask

    task automatic run_enc(input logic [23:0] kv, input bit disturb);
        int n;
        int lim;
        int lenv;
        lenv = int'(pt_mem[0]);
        lim = 256 + 6 * 256 + 8 * lenv + 8;
        wr_count = 0;
        @(negedge clk);
        en  = 1'b1;
        key = kv;
        @(negedge clk);
        en  = 1'b0;
        if (disturb) key = 24'($urandom);
        check("rdy_drop", 32'(rdy), 32'd0);
        n = 1;
        while (!rdy && n <= lim + 16) begin
            if (disturb) begin
                en  = 1'($urandom_range(0, 1));
                key = 24'($urandom);
            end
            @(negedge clk);
            if (!rdy) n++;
        end
        en = 1'b0;
        check("rdy_return", 32'(rdy), 32'd1);
        check("latency_ok", 32'(n <= lim), 32'd1);
        check("ct_write_count", 32'(wr_count), 32'(lenv + 1));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef ARC4_ENC_CYCLE_COUNT_EN
        check("cycle_count", cycles, 32'(n));
`endif
        exp_q.delete();
    endtask

    initial begin
        logic [23:0] rk;
        int n;
        total    = 0;
        bad      = 0;
        wr_count = 0;
        rst      = 1'b1;
        en       = 1'b0;
        key      = 24'h0;
        for (int a = 0; a < 256; a++) begin
            pt_mem[a] = 8'h00;
            s_mem[a]  = 8'h00;
        end
        #12;
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_ct_wren", 32'(ct_wren), 32'd0);
        check("reset_s_wren", 32'(s_wren), 32'd0);
        check("reset_addrs", {8'h00, pt_addr, ct_addr, s_addr}, 32'd0);
        check("reset_wrdata", {16'h0, ct_wrdata, s_wrdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Standard vector, then decrypt it back.
        load_std();
        push_std(1'b0);
        run_enc(24'h4B6579, 1'b0);
        for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
        push_std(1'b1);
        run_enc(24'h4B6579, 1'b0);

        // Empty message.
        pt_mem[0] = 8'h00;
        exp_q.push_back(16'h0000);
        run_enc(24'($urandom), 1'b0);

        // Maximum length and its round trip.
        load_random(255);
        for (int a = 0; a < 256; a++) orig[a] = pt_mem[a];
        push_model(24'h000018);
        run_enc(24'h000018, 1'b0);
        for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
        for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), orig[a]});
        run_enc(24'h000018, 1'b0);

        // en pulses and key changes while busy must not disturb the run.
        rk = 24'($urandom);
        load_random(20);
        push_model(rk);
        run_enc(rk, 1'b1);

        repeat (4) begin
            rk = 24'($urandom);
            load_random($urandom_range(1, 48));
            push_model(rk);
            run_enc(rk, 1'b0);
        end

        // Asynchronous reset in the middle of PRGA, then a clean rerun.
        load_std();
        push_std(1'b0);
        wr_count = 0;
        @(negedge clk);
        en  = 1'b1;
        key = 24'h4B6579;
        @(negedge clk);
        en  = 1'b0;
        n = 0;
        while (wr_count < 4 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("reached_prga", 32'(wr_count >= 4), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_rdy", 32'(rdy), 32'd1);
        check("midrun_reset_wren", {30'h0, ct_wren, s_wren}, 32'd0);
        check("midrun_reset_addrs", {8'h00, pt_addr, ct_addr, s_addr}, 32'd0);
        check("midrun_reset_wrdata", {16'h0, ct_wrdata, s_wrdata}, 32'd0);
`ifdef ARC4_ENC_CYCLE_COUNT_EN
        check("midrun_reset_cycles", cycles, 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_std(1'b0);
        run_enc(24'h4B6579, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arc4_encrypt_writer.md
Name: arc4_encrypt_writer

Overview:
- ARC4 encryption engine that produces the length-prefixed ciphertext image held in the CT memory, which the task4 cracker reads back.
- Takes a 24-bit key and reads a length-prefixed plaintext from a PT ROM.
- Runs ARC4 init, KSA and PRGA using an external 256x8 S RAM, and writes the length byte and ciphertext bytes into the CT RAM.
- Uses the same en/rdy handshake as the existing lab datapath blocks.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte n = key[8*(KEY_BYTES-n)-1 -: 8], i.e. big-endian, key[23:16] is byte 0.
- MSG_AW, 8, address width of the PT and CT memories.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  8*KEY_BYTES  encryption key; latched when en is accepted.
- pt_addr  out  MSG_AW  PT ROM address.
- pt_rddata  in  8  PT read data, 1-cycle synchronous latency.
- ct_addr  out  MSG_AW  CT RAM address.
- ct_wrdata  out  8  CT write data.
- ct_wren  out  1  CT write strobe.
- s_addr  out  8  S RAM address.
- s_rddata  in  8  S read data, 1-cycle latency.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write strobe.

Behaviour:
- Reset values: rdy=1; all addresses, write data and write strobes = 0; i, j, k and state = IDLE.
- Reset is asynchronous and takes effect mid-operation. The partial CT contents are left as-is and no further writes occur.
- Handshake:
  - en && rdy: latch key, drop rdy on the next edge, enter INIT.
  - en while rdy=0 is ignored.
  - rdy rises in the cycle after the last CT write.
- INIT: S[i]=i for i=0..255, one write per cycle, 256 cycles.
- KSA: j=0. For i=0..255: read S[i], j = j + S[i] + keybyte[i mod KEY_BYTES] (mod 256), read S[j], write S[i]=old S[j], write S[j]=old S[i].
- LEN:
  - Read PT[0] to get L.
  - Write CT[0]=L.
  - Reset i=0, j=0.
- PRGA: for k=1..L:
  - i = i+1 (mod 256).
  - Read S[i]; j = j + S[i].
  - Read S[j]; swap S[i] and S[j].
  - Read S[(S[i]+S[j]) mod 256] to get pad.
  - Read PT[k]; write CT[k] = PT[k] ^ pad.
- All sums are 8-bit and wrap silently. k never exceeds 255 (L ≤ 255).
- Every memory read allows exactly 1 cycle of latency before its data is used. No read and write to the same S address occur in the same cycle.
- L=0: only CT[0]=0 is written, then return to IDLE.
- Swap when i==j: the two writes store the same value, so S is unchanged. This must hold without corruption.
- ct_wren is asserted for exactly L+1 cycles per run. s_wren is low outside INIT/KSA/PRGA.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> IDLE. Sub-states per read/swap step are implementation choice; total latency is not fixed, but must not exceed 256 + 6*256 + 8*L + 8 cycles.

Optional Feature:
- ARC4_ENC_CYCLE_COUNT_EN defined:
  - Adds output cycles (32 bits).
  - Cleared to 0 on reset and on accepted en.
  - Increments every cycle while rdy=0.
  - Holds its value while rdy=1.
- ARC4_ENC_CYCLE_COUNT_EN undefined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Standard vector: key=24'h4B6579 ("Key"), PT = 09 50 6C 61 69 6E 74 65 78 74 -> CT = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy returns high; exactly 10 ct_wren pulses.
- Round trip: run once, copy the resulting CT into PT, rerun with key=24'h4B6579 -> CT equals the original "Plaintext" image (09 50 6C ...).
- L=0: PT[0]=00, any key -> single write CT[0]=00, no other CT writes, rdy high again.
- L=255 with key=24'h000018: 256 CT writes, addresses 0..255 in order, no write beyond 255; decrypting the result with the same key restores PT.
- en pulsed while busy, and key changed mid-run -> output is identical to an undisturbed run with the originally latched key.
- rst asserted mid-PRGA -> outputs go to reset values immediately, with no clock edge; a new en then produces the full correct CT for the standard vector.
